// File: rtl/ps2_paddle_ctrl.sv
// ps2_paddle_ctrl: decodes Set-2 make/break scan codes into held-key flags and
// drives a rate-limited, clamped paddle position plus a one-shot start pulse.
module ps2_paddle_ctrl #(
  parameter int MOVE_DIV = 500000,
  parameter int STEP     = 2,
  parameter int SCREEN_W = 160,
  parameter int PADDLE_W = 16,
  parameter int X_INIT   = 72
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  input  logic       enable,
  input  logic       recenter,
  output logic [7:0] paddle_x,
  output logic       left_held,
  output logic       right_held,
  output logic       start_pulse
);
  localparam int CW = $clog2(MOVE_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(MOVE_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [8:0] X_MAX9 = 9'(SCREEN_W - PADDLE_W);
  localparam logic [7:0] X_MAX8 = 8'(SCREEN_W - PADDLE_W);
  localparam logic [7:0] X_RST = 8'(X_INIT);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state_q, state_d;
  logic          ka_q, ka_d, kl_q, kl_d, kd_q, kd_d, kr_q, kr_d;
  logic          sp_q, sp_d, start_q, start_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d, dec, inc;
  logic          tick, left, right;

  always_comb begin
    state_d = state_q;
    ka_d    = ka_q;
    kl_d    = kl_q;
    kd_d    = kd_q;
    kr_d    = kr_q;
    sp_d    = sp_q;
    start_d = 1'b0;
    if (key_valid) begin
      case (state_q)
        IDLE: begin
          state_d = key_data == 8'hE0 ? EXT : key_data == 8'hF0 ? BRK : IDLE;
          if (key_data == 8'h1C) ka_d = 1'b1;
          if (key_data == 8'h23) kd_d = 1'b1;
          if (key_data == 8'h29) begin
            sp_d    = 1'b1;
            start_d = !sp_q;
          end
        end
        EXT: begin
          state_d = key_data == 8'hE0 ? EXT : key_data == 8'hF0 ? EXT_BRK : IDLE;
          if (key_data == 8'h6B) kl_d = 1'b1;
          if (key_data == 8'h74) kr_d = 1'b1;
        end
        BRK: begin
          state_d = IDLE;
          if (key_data == 8'h1C) ka_d = 1'b0;
          if (key_data == 8'h23) kd_d = 1'b0;
          if (key_data == 8'h29) sp_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          if (key_data == 8'h6B) kl_d = 1'b0;
          if (key_data == 8'h74) kr_d = 1'b0;
        end
      endcase
    end
  end

  // Movement uses the flags as registered before this edge, so a release
  // arriving with a tick only affects the following tick.
  always_comb begin
    left  = ka_q | kl_q;
    right = kd_q | kr_q;
    tick  = enable && cnt_q == CNT_MAX;
    cnt_d = (!enable || recenter || tick) ? '0 : cnt_q + CW'(1);
    dec   = x_q >= STEP8 ? x_q - STEP8 : 8'd0;
    inc   = {1'b0, x_q} + STEP9 <= X_MAX9 ? x_q + STEP8 : X_MAX8;
    x_d   = recenter ? X_RST : (!tick || left == right) ? x_q : left ? dec : inc;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      ka_q    <= 1'b0;
      kl_q    <= 1'b0;
      kd_q    <= 1'b0;
      kr_q    <= 1'b0;
      sp_q    <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= X_RST;
    end else begin
      state_q <= state_d;
      ka_q    <= ka_d;
      kl_q    <= kl_d;
      kd_q    <= kd_d;
      kr_q    <= kr_d;
      sp_q    <= sp_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign paddle_x    = x_q;
  assign left_held   = ka_q | kl_q;
  assign right_held  = kd_q | kr_q;
  assign start_pulse = start_q;
endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// tb_ps2_paddle_ctrl: directed stimulus for the paddle controller, checked every
// cycle against a behavioural model plus hand-computed literal expectations.
module tb_ps2_paddle_ctrl;
  localparam int MD = 4, ST = 2, XI = 72, XMAX = 144;

  logic       clock = 1'b0, resetn = 1'b0, key_valid = 1'b0, enable = 1'b0, recenter = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic [7:0] paddle_x;
  logic       left_held, right_held, start_pulse;

  int checks = 0, passes = 0, pulses = 0;
  int mx = XI, run = 0;
  bit m_ext, m_brk, ka, kl, kd, kr, sp, m_start, m_init;

  ps2_paddle_ctrl #(.MOVE_DIV(MD), .STEP(ST)) dut (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_valid(key_valid),
    .enable(enable), .recenter(recenter), .paddle_x(paddle_x),
    .left_held(left_held), .right_held(right_held), .start_pulse(start_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: held keys as a set of booleans, pending prefixes as two bits,
  // position as a plain integer clamped into the playfield.
  always @(posedge clock) begin
    bit l, r, tick, val;
    logic [8:0] code;
    if (!resetn) begin
      {m_ext, m_brk, ka, kl, kd, kr, sp, m_start} = '0;
      mx = XI; run = 0; m_init = 1'b1;
    end else begin
      l = ka | kl;
      r = kd | kr;
      tick = enable && (run % MD == MD - 1);
      run = (!enable || recenter) ? 0 : run + 1;
      if (recenter) mx = XI;
      else if (tick && l && !r) mx = (mx - ST < 0) ? 0 : mx - ST;
      else if (tick && r && !l) mx = (mx + ST > XMAX) ? XMAX : mx + ST;
      m_start = 1'b0;
      if (key_valid) begin
        if (!m_brk && key_data == 8'hE0) m_ext = 1'b1;
        else if (!m_brk && key_data == 8'hF0) m_brk = 1'b1;
        else begin
          val = !m_brk;
          code = {m_ext, key_data};
          if (code == 9'h01C) ka = val;
          if (code == 9'h023) kd = val;
          if (code == 9'h16B) kl = val;
          if (code == 9'h174) kr = val;
          if (code == 9'h029) begin
            if (val && !sp) m_start = 1'b1;
            sp = val;
          end
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      chk("paddle_x", paddle_x, mx);
      chk("left_held", left_held, ka | kl);
      chk("right_held", right_held, kd | kr);
      chk("start_pulse", start_pulse, m_start);
      chk("x_in_range", int'(paddle_x <= XMAX), 1);
      if (start_pulse) pulses++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    key_data = b;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  initial begin
    step(3);
    resetn = 1'b1;
    chk("rst_x", paddle_x, 72);
    chk("rst_left", left_held, 0);
    chk("rst_right", right_held, 0);
    chk("rst_start", start_pulse, 0);
    step(20);
    chk("idle_x", paddle_x, 72);

    enable = 1'b1;
    send(8'h1C);
    chk("a_held", left_held, 1);
    step(11);
    chk("left_3_ticks", paddle_x, 66);
    send(8'hF0); send(8'h1C);
    chk("a_released", left_held, 0);
    step(20);
    chk("hold_after_release", paddle_x, 66);

    send(8'hE0); send(8'h74);
    chk("rarrow_held", right_held, 1);
    step(200);
    chk("saturate_right", paddle_x, 144);
    send(8'hE0); send(8'hF0); send(8'h74);
    step(8);
    chk("rarrow_released", right_held, 0);
    chk("stay_144", paddle_x, 144);

    pulses = 0;
    send(8'h29); send(8'h29); send(8'h29);
    send(8'hF0); send(8'h29); send(8'h29);
    step(3);
    chk("start_pulse_count", pulses, 2);

    recenter = 1'b1; step(1); recenter = 1'b0;
    chk("recenter_x", paddle_x, 72);
    send(8'h1C); send(8'hE0); send(8'h74);
    step(20);
    chk("both_held_x", paddle_x, 72);
    send(8'hF0); send(8'h1C);
    step(8);
    chk("moved_right", int'(paddle_x > 72), 1);
    send(8'hE0); send(8'h1C);
    chk("ext_unknown_left", left_held, 0);
    chk("ext_unknown_right", right_held, 1);
    send(8'hE0); send(8'hF0); send(8'h74);

    send(8'h1C);
    for (int i = 0; i < 400 && paddle_x != 8'd10; i++) step(1);
    chk("reach_10", paddle_x, 10);
    send(8'hF0); send(8'h1C);
    step(1);
    recenter = 1'b1; step(1); recenter = 1'b0;
    chk("recenter_on_tick", paddle_x, 72);
    send(8'h23);
    step(2);
    chk("no_tick_yet", paddle_x, 72);
    step(1);
    chk("tick_after_recenter", paddle_x, 74);
    send(8'hF0); send(8'h23);

    send(8'hE0);
    resetn = 1'b0; step(1); resetn = 1'b1;
    chk("midseq_rst_x", paddle_x, 72);
    send(8'h74);
    chk("plain_74_ignored", right_held, 0);
    send(8'h1C);
    chk("idle_after_rst", left_held, 1);
    step(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
